// File: rtl/debounce_bank.sv
// debounce_bank: per-channel 2-flop synchroniser, tick-sampled stability filter and edge pulses.
// Define DEBOUNCE_REPEAT_EN to build the hold-to-repeat pulse generator; otherwise o_repeat is 0.
module debounce_bank #(
   parameter int unsigned CHANNELS     = 5,
   parameter int unsigned TICK_DIV     = 12500,
   parameter int unsigned STABLE_CNT   = 4,
   parameter int unsigned REPEAT_DELAY = 40,
   parameter int unsigned REPEAT_RATE  = 10
) (
   input  logic                i_clk,
   input  logic                i_rst_n,
   input  logic [CHANNELS-1:0] i_raw,
   output logic [CHANNELS-1:0] o_level,
   output logic [CHANNELS-1:0] o_pressed,
   output logic [CHANNELS-1:0] o_released,
   output logic [CHANNELS-1:0] o_repeat,
   output logic                o_tick
);

   localparam int unsigned TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int unsigned SW = (STABLE_CNT > 1) ? $clog2(STABLE_CNT) : 1;
   localparam logic [TW-1:0] TickLast   = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] StableLast = SW'(STABLE_CNT - 1);

   logic [CHANNELS-1:0]         r_sync1, r_sync2;
   logic [TW-1:0]               r_tick_cnt, w_tick_cnt_d;
   logic                        r_tick, w_tick_wrap;
   logic [CHANNELS-1:0][SW-1:0] r_stab, w_stab_d;
   logic [CHANNELS-1:0]         r_level, w_level_d;
   logic [CHANNELS-1:0]         r_pressed, w_pressed_d;
   logic [CHANNELS-1:0]         r_released, w_released_d;
   logic [CHANNELS-1:0]         w_toggle;

   always_comb begin
      w_tick_wrap  = (r_tick_cnt == TickLast);
      w_tick_cnt_d = w_tick_wrap ? '0 : r_tick_cnt + TW'(1);
   end

   // Filter only advances on the registered tick; any sample equal to the level restarts it.
   always_comb begin
      w_stab_d     = r_stab;
      w_level_d    = r_level;
      w_pressed_d  = '0;
      w_released_d = '0;
      w_toggle     = '0;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         if (r_tick) begin
            if (r_sync2[i] == r_level[i]) begin
               w_stab_d[i] = '0;
            end else if (r_stab[i] == StableLast) begin
               w_stab_d[i]     = '0;
               w_level_d[i]    = r_sync2[i];
               w_pressed_d[i]  = r_sync2[i];
               w_released_d[i] = ~r_sync2[i];
               w_toggle[i]     = 1'b1;
            end else begin
               w_stab_d[i] = r_stab[i] + SW'(1);
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_sync1    <= '0;
         r_sync2    <= '0;
         r_tick_cnt <= '0;
         r_tick     <= 1'b0;
         r_stab     <= '0;
         r_level    <= '0;
         r_pressed  <= '0;
         r_released <= '0;
      end else begin
         r_sync1    <= i_raw;
         r_sync2    <= r_sync1;
         r_tick_cnt <= w_tick_cnt_d;
         r_tick     <= w_tick_wrap;
         r_stab     <= w_stab_d;
         r_level    <= w_level_d;
         r_pressed  <= w_pressed_d;
         r_released <= w_released_d;
      end
   end

   assign o_level    = r_level;
   assign o_pressed  = r_pressed;
   assign o_released = r_released;
   assign o_tick     = r_tick;

`ifdef DEBOUNCE_REPEAT_EN
   localparam int unsigned RMax = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
   localparam int unsigned RW   = $clog2(RMax + 1);
   localparam logic [RW-1:0] RepDelay = RW'(REPEAT_DELAY);
   localparam logic [RW-1:0] RepRate  = RW'(REPEAT_RATE);
   localparam logic [RW-1:0] RepMax   = RW'(RMax);

   logic [CHANNELS-1:0][RW-1:0] r_rep_cnt, w_rep_cnt_d, w_rep_inc;
   logic [CHANNELS-1:0]         r_rep_run, w_rep_run_d;
   logic [CHANNELS-1:0]         r_repeat, w_repeat_d;

   // r_rep_run marks that the first (delayed) pulse has gone out; later pulses use the rate.
   always_comb begin
      w_rep_cnt_d = r_rep_cnt;
      w_rep_run_d = r_rep_run;
      w_repeat_d  = '0;
      w_rep_inc   = r_rep_cnt;
      for (int i = 0; i < int'(CHANNELS); i++) begin
         w_rep_inc[i] = (r_rep_cnt[i] == RepMax) ? RepMax : r_rep_cnt[i] + RW'(1);
         if (!r_level[i] || w_toggle[i]) begin
            w_rep_cnt_d[i] = '0;
            w_rep_run_d[i] = 1'b0;
         end else if (r_tick) begin
            if (w_rep_inc[i] == (r_rep_run[i] ? RepRate : RepDelay)) begin
               w_rep_cnt_d[i] = '0;
               w_rep_run_d[i] = 1'b1;
               w_repeat_d[i]  = 1'b1;
            end else begin
               w_rep_cnt_d[i] = w_rep_inc[i];
            end
         end
      end
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_rep_cnt <= '0;
         r_rep_run <= '0;
         r_repeat  <= '0;
      end else begin
         r_rep_cnt <= w_rep_cnt_d;
         r_rep_run <= w_rep_run_d;
         r_repeat  <= w_repeat_d;
      end
   end

   assign o_repeat = r_repeat;
`else
   assign o_repeat = '0;
`endif

endmodule

// File: tb/tb_debounce_bank.sv
// Directed bench for debounce_bank: reset, clean edges, bounce, simultaneous edges,
// mid-count reset and (when DEBOUNCE_REPEAT_EN is defined) hold-to-repeat timing.
module tb_debounce_bank;
   localparam int unsigned CH = 5;
   localparam int unsigned TD = 4;
   localparam int unsigned SC = 3;
   localparam int unsigned RD = 5;
   localparam int unsigned RR = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [CH-1:0] raw;
   logic [CH-1:0] level, pressed, released, rpt;
   logic          tick;

   always #5 clk = ~clk;

   debounce_bank #(
      .CHANNELS    (CH),
      .TICK_DIV    (TD),
      .STABLE_CNT  (SC),
      .REPEAT_DELAY(RD),
      .REPEAT_RATE (RR)
   ) dut (
      .i_clk     (clk),
      .i_rst_n   (rst_n),
      .i_raw     (raw),
      .o_level   (level),
      .o_pressed (pressed),
      .o_released(released),
      .o_repeat  (rpt),
      .o_tick    (tick)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int cyc      = 0;
   int tick_n   = 0;
   int viol_tick = 0, viol_width = 0, viol_coinc = 0, viol_rep_low = 0;
   int press4_cyc = 0, rep4_n = 0, rep_idx = 0;
   int press_n[CH];
   int rel_n[CH];
   int rep_off[3];
   logic [CH-1:0] press_or, rel_or, lvl_or, rpt_or;
   logic [CH-1:0] prev_p, prev_r, prev_rep;
   logic          prev_tick;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) begin
         n_pass++;
      end else begin
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Advance one clock and sample 1 time unit after the edge, updating running observations.
   task automatic step();
      @(posedge clk);
      #1;
      cyc++;
      if (tick) tick_n++;
      press_or |= pressed;
      rel_or   |= released;
      lvl_or   |= level;
      rpt_or   |= rpt;
      for (int i = 0; i < int'(CH); i++) begin
         if (pressed[i])  press_n[i]++;
         if (released[i]) rel_n[i]++;
      end
      if (((pressed | released) != '0) && !prev_tick) viol_tick++;
      if (((pressed & prev_p) | (released & prev_r) | (rpt & prev_rep)) != '0) viol_width++;
      if ((rpt & (pressed | released)) != '0) viol_coinc++;
      if ((rpt & ~level) != '0) viol_rep_low++;
      if (pressed[4]) press4_cyc = cyc;
      if (rpt[4]) begin
         rep4_n++;
         if (rep_idx < 3) begin
            rep_off[rep_idx] = cyc - press4_cyc;
            rep_idx++;
         end
      end
      prev_tick = tick;
      prev_p    = pressed;
      prev_r    = released;
      prev_rep  = rpt;
   endtask

   task automatic clr();
      press_or = '0;
      rel_or   = '0;
      lvl_or   = '0;
      for (int i = 0; i < int'(CH); i++) begin
         press_n[i] = 0;
         rel_n[i]   = 0;
      end
   endtask

   task automatic wait_level(input int ch, input logic val, input int maxc, output int c);
      c = -1;
      for (int k = 1; k <= maxc; k++) begin
         step();
         if (level[ch] === val) begin
            c = k;
            break;
         end
      end
   endtask

   int c, rel0c, pr2c, sum;

   initial begin
      raw       = 5'b11111;
      rst_n     = 1'b0;
      prev_tick = 1'b0;
      prev_p    = '0;
      prev_r    = '0;
      prev_rep  = '0;
      rpt_or    = '0;
      rep_off[0] = -1;
      rep_off[1] = -1;
      rep_off[2] = -1;
      clr();

      // Reset held with all buttons pressed
      repeat (20) step();
      chk("rst_level", 32'(level), 0);
      chk("rst_pressed", 32'(pressed), 0);
      chk("rst_released", 32'(released), 0);
      chk("rst_repeat", 32'(rpt), 0);
      chk("rst_tick", 32'(tick), 0);

      rst_n = 1'b1;
      clr();
      wait_level(0, 1'b1, 20, c);
      chk("rst_rel_window", 32'(c >= 9 && c <= 14), 1);
      chk("rst_rel_latency", c, 13);
      chk("rst_rel_level", 32'(level), 'h1f);
      chk("rst_rel_pressed", 32'(pressed), 'h1f);
      step();
      chk("rst_rel_press_width", 32'(pressed), 0);

      // Release everything; also measures tick period
      raw = '0;
      clr();
      tick_n = 0;
      repeat (40) step();
      chk("tick_period", tick_n, 10);
      chk("all_rel_level", 32'(level), 0);
      chk("all_rel_mask", 32'(rel_or), 'h1f);
      sum = 0;
      for (int i = 0; i < int'(CH); i++) sum += rel_n[i];
      chk("all_rel_count", sum, 5);

      // Clean press / release on channel 0
      clr();
      raw[0] = 1'b1;
      wait_level(0, 1'b1, 20, c);
      chk("press0_window", 32'(c >= 9 && c <= 14), 1);
      chk("press0_pulse", 32'(pressed), 'h01);
      step();
      chk("press0_width", 32'(pressed), 0);
      repeat (15) step();
      chk("press0_count", press_n[0], 1);
      chk("press0_only", 32'(press_or), 'h01);
      chk("press0_no_rel", 32'(rel_or), 0);
      chk("press0_level", 32'(level), 'h01);

      clr();
      raw[0] = 1'b0;
      wait_level(0, 1'b0, 20, c);
      chk("rel0_window", 32'(c >= 9 && c <= 14), 1);
      chk("rel0_pulse", 32'(released), 'h01);
      repeat (15) step();
      chk("rel0_count", rel_n[0], 1);
      chk("rel0_no_press", 32'(press_or), 0);
      chk("rel0_level", 32'(level), 0);

      // Bounce on channel 1: 5-cycle half period never spans 3 samples
      clr();
      for (int k = 0; k < 40; k++) begin
         raw[1] = (k % 2 == 0);
         repeat (5) step();
      end
      chk("bounce_level", 32'(lvl_or), 0);
      chk("bounce_pulses", 32'(press_or | rel_or), 0);
      clr();
      raw[1] = 1'b1;
      repeat (30) step();
      chk("bounce_hold_press", press_n[1], 1);
      chk("bounce_hold_level", 32'(level), 'h02);

      // Simultaneous release on 0 and press on 2
      raw[0] = 1'b1;
      repeat (30) step();
      chk("simul_setup", 32'(level), 'h03);
      clr();
      rel0c = -1;
      pr2c  = -2;
      raw[0] = 1'b0;
      raw[2] = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if (released[0]) rel0c = k;
         if (pressed[2])  pr2c  = k;
      end
      chk("simul_same_cycle", rel0c, pr2c);
      chk("simul_window", 32'(rel0c >= 9 && rel0c <= 14), 1);
      chk("simul_level", 32'(level), 'h06);

      // Reset in the middle of a channel-3 count
      clr();
      raw[3] = 1'b1;
      tick_n = 0;
      for (int k = 0; k < 20; k++) begin
         step();
         if (tick_n == 2) break;
      end
      chk("mid_pre_level3", 32'(level[3]), 0);
      rst_n = 1'b0;
      step();
      chk("mid_rst_level", 32'(level), 0);
      rst_n = 1'b1;
      clr();
      wait_level(3, 1'b1, 20, c);
      chk("mid_latency", c, 13);
      chk("mid_press3_single", press_n[3], 1);
      chk("mid_pressed", 32'(pressed), 'h0e);

      // Hold channel 4 for repeats, then release
      repeat (10) step();
      clr();
      rep4_n  = 0;
      rep_idx = 0;
      raw[4] = 1'b1;
      wait_level(4, 1'b1, 20, c);
      chk("hold4_window", 32'(c >= 9 && c <= 14), 1);
      repeat (38) step();
      raw[4] = 1'b0;
      wait_level(4, 1'b0, 20, c);
      chk("rel4_window", 32'(c >= 9 && c <= 14), 1);
      repeat (40) step();
`ifdef DEBOUNCE_REPEAT_EN
      chk("rep_first", rep_off[0], RD * TD);
      chk("rep_second", rep_off[1], (RD + RR) * TD);
      chk("rep_third", rep_off[2], (RD + 2 * RR) * TD);
      chk("rep_total", rep4_n, 4);
      chk("rep_mask", 32'(rpt_or), 'h10);
`else
      chk("rep_off_total", rep4_n, 0);
      chk("rep_off_mask", 32'(rpt_or), 0);
`endif

      chk("pulse_after_tick", viol_tick, 0);
      chk("pulse_width", viol_width, 0);
      chk("rep_coincident", viol_coinc, 0);
      chk("rep_while_low", viol_rep_low, 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end
endmodule
